// File: rtl/booth_mul_iter_pkg.sv
// Shared definitions for the iterative radix-4 Booth multiplier.
//   - FSM state encoding (IDLE/CALC/DONE)
//   - geometry constants: Booth group count, extended-y register width,
//     product width, step counter width
//   - helper used for early termination (all-0 / all-1 test of the y register)
package booth_mul_iter_pkg;

  localparam int MUL_GROUPS = 17;
  localparam int MUL_YREG_W = 35;
  localparam int MUL_PROD_W = 64;
  localparam int MUL_CNT_W  = 5;

  localparam logic [MUL_CNT_W-1:0] MUL_LAST_CNT = MUL_CNT_W'(MUL_GROUPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

  // A y register that is all zeros or all ones selects a zero partial
  // product in every remaining Booth group.
  function automatic logic yreg_uniform(input logic [MUL_YREG_W-1:0] y);
    return (y == '0) || (y == '1);
  endfunction

endpackage

// File: rtl/booth_mul_iter_booth.sv
// Radix-4 Booth partial-product selector.
// Ports:
//   y_2_0     in   3  Booth window {y[2i+1], y[2i], y[2i-1]}
//   exponent  in   5  group position; the selected multiple is shifted left by 2*exponent
//   x_pos     in  64  +x
//   x_neg     in  64  -x
//   x2_pos    in  64  +2x
//   x2_neg    in  64  -2x
//   pp        out 64  selected, shifted partial product
module booth_mul_iter_booth
  import booth_mul_iter_pkg::*;
(
  input  logic        [2:0]            y_2_0,
  input  logic        [4:0]            exponent,
  input  logic signed [MUL_PROD_W-1:0] x_pos,
  input  logic signed [MUL_PROD_W-1:0] x_neg,
  input  logic signed [MUL_PROD_W-1:0] x2_pos,
  input  logic signed [MUL_PROD_W-1:0] x2_neg,
  output logic signed [MUL_PROD_W-1:0] pp
);

  logic signed [MUL_PROD_W-1:0] sel;

  always_comb begin
    case (y_2_0)
      3'b001, 3'b010: sel = x_pos;
      3'b011:         sel = x2_pos;
      3'b100:         sel = x2_neg;
      3'b101, 3'b110: sel = x_neg;
      default:        sel = '0;
    endcase
    pp = sel <<< {exponent, 1'b0};
  end

endmodule

// File: rtl/booth_mul_iter.sv
// Iterative radix-4 Booth multiplier (MUL/MULH/MULHU), one Booth group per cycle.
// Parameters:
//   EARLY_TERM  1: stop as soon as the remaining y bits are uniform; 0: always 17 steps
// Ports:
//   clk         in   1  clock
//   reset       in   1  synchronous active-high reset
//   flush       in   1  cancel in-flight op, result discarded
//   mul_valid   in   1  operand request valid
//   mul_ready   out  1  request can be accepted (IDLE only)
//   mul_signed  in   1  1: signed x signed, 0: unsigned x unsigned
//   mul_x       in  32  multiplicand
//   mul_y       in  32  multiplier
//   res_valid   out  1  product valid, held until res_ready
//   res_ready   in   1  consumer accepts product
//   res_prod    out 64  product {hi, lo}
module booth_mul_iter
  import booth_mul_iter_pkg::*;
#(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  mul_valid,
  output logic                  mul_ready,
  input  logic                  mul_signed,
  input  logic [31:0]           mul_x,
  input  logic [31:0]           mul_y,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [MUL_PROD_W-1:0] res_prod
);

  mul_state_e                   state_q, state_d;
  logic [MUL_CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [MUL_PROD_W-1:0] acc_q, acc_d;
  logic [MUL_PROD_W-1:0]        res_prod_q, res_prod_d;
  logic                         res_valid_q, res_valid_d;
  logic                         mul_ready_q, mul_ready_d;
  logic signed [MUL_PROD_W-1:0] x1_q, x1_d;
  logic signed [MUL_PROD_W-1:0] xn1_q, xn1_d;
  logic signed [MUL_PROD_W-1:0] x2_q, x2_d;
  logic signed [MUL_PROD_W-1:0] xn2_q, xn2_d;
  logic [MUL_YREG_W-1:0]        y_q, y_d;

  logic signed [MUL_PROD_W-1:0] x_ext;
  logic                         y_ext;
  logic signed [MUL_PROD_W-1:0] pp;
  logic signed [MUL_PROD_W-1:0] acc_sum;
  logic [MUL_YREG_W-1:0]        y_shift;
  logic                         last_step;

  booth_mul_iter_booth u_booth (
    .y_2_0    (y_q[2:0]),
    .exponent (5'd0),
    .x_pos    (x1_q),
    .x_neg    (xn1_q),
    .x2_pos   (x2_q),
    .x2_neg   (xn2_q),
    .pp       (pp)
  );

  always_comb begin
    x_ext     = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'd0, mul_x};
    y_ext     = mul_signed & mul_y[31];
    acc_sum   = acc_q + pp;
    y_shift   = {{2{y_q[MUL_YREG_W-1]}}, y_q[MUL_YREG_W-1:2]};
    // With early termination the post-shift register (including the next
    // window) being uniform means all remaining groups contribute zero.
    last_step = (cnt_q == MUL_LAST_CNT) || (EARLY_TERM && yreg_uniform(y_shift));

    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    res_prod_d  = res_prod_q;
    res_valid_d = res_valid_q;
    mul_ready_d = mul_ready_q;
    x1_d        = x1_q;
    xn1_d       = xn1_q;
    x2_d        = x2_q;
    xn2_d       = xn2_q;
    y_d         = y_q;

    case (state_q)
      ST_IDLE: begin
        if (mul_valid) begin
          state_d     = ST_CALC;
          mul_ready_d = 1'b0;
          x1_d        = x_ext;
          xn1_d       = -x_ext;
          x2_d        = x_ext <<< 1;
          xn2_d       = -(x_ext <<< 1);
          y_d         = {{2{y_ext}}, mul_y, 1'b0};
          acc_d       = '0;
          cnt_d       = '0;
        end
      end
      ST_CALC: begin
        acc_d = acc_sum;
        x1_d  = x1_q <<< 2;
        xn1_d = xn1_q <<< 2;
        x2_d  = x2_q <<< 2;
        xn2_d = xn2_q <<< 2;
        y_d   = y_shift;
        cnt_d = cnt_q + MUL_CNT_W'(1);
        if (last_step) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
          res_prod_d  = acc_sum;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          mul_ready_d = 1'b1;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        res_valid_d = 1'b0;
        mul_ready_d = 1'b1;
      end
    endcase

    // Flush overrides everything, including a request arriving in IDLE.
    if (flush) begin
      state_d     = ST_IDLE;
      res_valid_d = 1'b0;
      res_prod_d  = '0;
      mul_ready_d = 1'b1;
      acc_d       = '0;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      res_prod_q  <= '0;
      res_valid_q <= 1'b0;
      mul_ready_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      res_prod_q  <= res_prod_d;
      res_valid_q <= res_valid_d;
      mul_ready_q <= mul_ready_d;
    end
    // Operand shift registers are only meaningful while CALC is active.
    x1_q  <= x1_d;
    xn1_q <= xn1_d;
    x2_q  <= x2_d;
    xn2_q <= xn2_d;
    y_q   <= y_d;
  end

  assign mul_ready = mul_ready_q;
  assign res_valid = res_valid_q;
  assign res_prod  = res_prod_q;

endmodule

// File: tb/tb_booth_mul_iter.sv
// Testbench for booth_mul_iter: instance 0 has EARLY_TERM=0, instance 1 has EARLY_TERM=1.
module tb_booth_mul_iter;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       flush, mul_valid, mul_signed, res_ready;
  logic [1:0][31:0] mul_x, mul_y;
  logic [1:0]       mul_ready, res_valid;
  logic [1:0][63:0] res_prod;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  booth_mul_iter #(.EARLY_TERM(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .flush(flush[0]), .mul_valid(mul_valid[0]),
    .mul_ready(mul_ready[0]), .mul_signed(mul_signed[0]), .mul_x(mul_x[0]),
    .mul_y(mul_y[0]), .res_valid(res_valid[0]), .res_ready(res_ready[0]),
    .res_prod(res_prod[0])
  );

  booth_mul_iter #(.EARLY_TERM(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .flush(flush[1]), .mul_valid(mul_valid[1]),
    .mul_ready(mul_ready[1]), .mul_signed(mul_signed[1]), .mul_x(mul_x[1]),
    .mul_y(mul_y[1]), .res_valid(res_valid[1]), .res_ready(res_ready[1]),
    .res_prod(res_prod[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference product from plain 64-bit arithmetic.
  function automatic logic [63:0] ref_prod(input bit sgn, input logic [31:0] x, input logic [31:0] y);
    longint a, b;
    a = sgn ? longint'($signed(x)) : longint'({32'd0, x});
    b = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    return 64'(a * b);
  endfunction

  // Number of radix-4 steps with early termination: the smallest k >= 1 such
  // that the multiplier bits from position 2k-1 upward are all equal, capped at 17.
  function automatic int ref_steps(input bit sgn, input logic [31:0] y);
    longint yv;
    yv = sgn ? longint'($signed(y)) : longint'({32'd0, y});
    for (int k = 1; k <= 16; k++) begin
      if (((yv >>> (2 * k - 1)) == 0) || ((yv >>> (2 * k - 1)) == -1)) return k;
    end
    return 17;
  endfunction

  // One operation on instance d. bp: cycles res_ready is held low once the
  // product is valid. fl: flush during the fl-th CALC cycle (0 = never).
  task automatic do_op(input int d, input bit sgn, input logic [31:0] x, input logic [31:0] y,
                       input int bp, input int fl,
                       output logic [63:0] p, output int lat, output bit flushed);
    int w;
    flushed = 1'b0;
    p       = '0;
    lat     = 0;
    w       = 0;
    while (!mul_ready[d] && w < 40) begin
      @(posedge clk); #1;
      w++;
    end
    mul_valid[d]  = 1'b1;
    mul_signed[d] = sgn;
    mul_x[d]      = x;
    mul_y[d]      = y;
    res_ready[d]  = (bp == 0);
    @(posedge clk); #1;
    mul_valid[d] = 1'b0;
    lat = 1;
    while (!res_valid[d] && lat < 40) begin
      if (fl != 0 && lat == fl) begin
        flush[d] = 1'b1;
        @(posedge clk); #1;
        flush[d] = 1'b0;
        flushed  = 1'b1;
        chk($sformatf("flush_ready%0d", d), 64'(mul_ready[d]), 64'd1);
        chk($sformatf("flush_valid%0d", d), 64'(res_valid[d]), 64'd0);
        chk($sformatf("flush_prod%0d", d), res_prod[d], 64'd0);
        return;
      end
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("res_valid_seen%0d", d), 64'(res_valid[d]), 64'd1);
    if (!res_valid[d]) return;
    p = res_prod[d];
    for (int i = 0; i < bp; i++) begin
      mul_valid[d] = 1'b1;
      mul_x[d]     = 32'h0000_0009;
      mul_y[d]     = 32'h0000_000B;
      @(posedge clk); #1;
      mul_valid[d] = 1'b0;
      chk($sformatf("hold_valid%0d", d), 64'(res_valid[d]), 64'd1);
      chk($sformatf("hold_prod%0d", d), res_prod[d], p);
      chk($sformatf("hold_ready%0d", d), 64'(mul_ready[d]), 64'd0);
    end
    res_ready[d] = 1'b1;
    @(posedge clk); #1;
    res_ready[d] = 1'b0;
    chk($sformatf("release_valid%0d", d), 64'(res_valid[d]), 64'd0);
    chk($sformatf("release_ready%0d", d), 64'(mul_ready[d]), 64'd1);
    chk($sformatf("idle_prod_held%0d", d), res_prod[d], p);
  endtask

  typedef struct {
    bit          sgn;
    logic [31:0] x;
    logic [31:0] y;
    logic [63:0] prod;
    int          lat_et;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] p;
    int          lat;
    bit          fl_hit;
    bit          seen;
    int          d, bp, fl;
    bit          sgn;
    logic [31:0] x, y;

    vecs[0] = '{1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001, 17};
    vecs[1] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, 2};
    vecs[2] = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, 18};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 17};
    vecs[4] = '{1'b0, 32'h8000_0000, 32'h0000_0002, 64'h0000_0001_0000_0000, 3};
    vecs[5] = '{1'b0, 32'h0000_0003, 32'h0000_0005, 64'd15, 3};
    vecs[6] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF9, 2};
    vecs[7] = '{1'b1, 32'h1234_5678, 32'h0000_0000, 64'd0, 2};
    vecs[8] = '{1'b1, 32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 3};

    reset      = 1'b1;
    flush      = '0;
    mul_valid  = '0;
    mul_signed = '0;
    res_ready  = '0;
    mul_x      = '0;
    mul_y      = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("reset_ready%0d", i), 64'(mul_ready[i]), 64'd1);
      chk($sformatf("reset_valid%0d", i), 64'(res_valid[i]), 64'd0);
      chk($sformatf("reset_prod%0d", i), res_prod[i], 64'd0);
    end
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed vectors on both instances.
    for (int i = 0; i < 9; i++) begin
      for (int k = 0; k < 2; k++) begin
        do_op(k, vecs[i].sgn, vecs[i].x, vecs[i].y, 0, 0, p, lat, fl_hit);
        chk($sformatf("tbl_prod[%0d]dut%0d", i, k), p, vecs[i].prod);
        chk($sformatf("tbl_lat[%0d]dut%0d", i, k), 64'(lat), (k == 0) ? 64'd18 : 64'(vecs[i].lat_et));
      end
    end

    // Backpressure: res_ready low for 5 cycles in DONE, requests ignored meanwhile.
    do_op(1, 1'b1, 32'h0000_0064, 32'hFFFF_FFF0, 5, 0, p, lat, fl_hit);
    chk("bp_prod", p, 64'hFFFF_FFFF_FFFF_F9C0);
    do_op(0, 1'b0, 32'hDEAD_BEEF, 32'h0000_1000, 5, 0, p, lat, fl_hit);
    chk("bp_prod_et0", p, 64'h0000_0DEA_DBEE_F000);

    // Flush on the 4th CALC cycle, then a clean op must not see stale state.
    do_op(0, 1'b1, 32'h1357_9BDF, 32'h8642_0ECA, 0, 4, p, lat, fl_hit);
    chk("flush_taken", 64'(fl_hit), 64'd1);
    do_op(0, 1'b0, 32'd6, 32'd7, 0, 0, p, lat, fl_hit);
    chk("after_flush_prod", p, 64'd42);
    chk("after_flush_lat", 64'(lat), 64'd18);

    // flush together with mul_valid in IDLE: request rejected.
    flush[1]     = 1'b1;
    mul_valid[1] = 1'b1;
    mul_signed[1] = 1'b0;
    mul_x[1]     = 32'd5;
    mul_y[1]     = 32'd5;
    @(posedge clk); #1;
    flush[1]     = 1'b0;
    mul_valid[1] = 1'b0;
    chk("flush_reject_ready", 64'(mul_ready[1]), 64'd1);
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (res_valid[1]) seen = 1'b1;
    end
    chk("flush_reject_no_result", 64'(seen), 64'd0);

    // Reset in the middle of an op: no partial result, power-on state.
    mul_valid[0]  = 1'b1;
    mul_signed[0] = 1'b1;
    mul_x[0]      = 32'h0BAD_F00D;
    mul_y[0]      = 32'h7654_3210;
    @(posedge clk); #1;
    mul_valid[0] = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_ready", 64'(mul_ready[0]), 64'd1);
    chk("midreset_valid", 64'(res_valid[0]), 64'd0);
    chk("midreset_prod", res_prod[0], 64'd0);
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (res_valid[0]) seen = 1'b1;
    end
    chk("midreset_no_result", 64'(seen), 64'd0);

    // Randomized ops with backpressure and occasional flush.
    for (int n = 0; n < 3200; n++) begin
      d   = (n < 1200) ? 0 : 1;
      sgn = 1'($urandom_range(0, 1));
      x   = $urandom;
      case ($urandom_range(0, 4))
        0:       y = $urandom & 32'h0000_00FF;
        1:       y = $urandom | 32'hFFFF_FF00;
        2:       y = $urandom >> $urandom_range(0, 31);
        3:       y = (($urandom_range(0, 1) == 0) ? 32'h0 : 32'hFFFF_FFFF);
        default: y = $urandom;
      endcase
      bp = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      fl = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 20)) : 0;
      do_op(d, sgn, x, y, bp, fl, p, lat, fl_hit);
      if (!fl_hit) begin
        chk($sformatf("rand_prod dut%0d s=%0d x=%h y=%h", d, sgn, x, y), p, ref_prod(sgn, x, y));
        chk($sformatf("rand_lat dut%0d s=%0d y=%h", d, sgn, y), 64'(lat),
            (d == 0) ? 64'd18 : 64'(1 + ref_steps(sgn, y)));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
